// File: rtl/painel_scroll_controller.sv
// Scroll sequencer for the panel's circular row registers: preset load, then timed shift commands.
// Optional build macro PAUSE_AT_WRAP_EN holds the scroll for PAUSE_TICKS steps after every frame wrap.
module painel_scroll_controller #(
  parameter int DIV         = 50_000_000,
  parameter int FRAME_LEN   = 16,
  parameter int PAUSE_TICKS = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       stop,
  input  logic       reload,
  input  logic       dir,
  input  logic       bounce,
  output logic       ch0,
  output logic       ch1,
  output logic       busy,
  output logic [3:0] step,
  output logic       frame_done
);

  // state | meaning
  // LOAD  | emit one preset-load command, clear column offset
  // IDLE  | hold, wait for start without stop
  // RUN   | divider running, one shift command per DIV cycles
  // PAUSE | hold after a frame wrap (PAUSE_AT_WRAP_EN builds only)
  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_RUN, S_PAUSE} state_t;

  localparam int             DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_TC  = DW'(DIV - 1);
  localparam logic [3:0]     STEP_TC = 4'(FRAME_LEN - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    step_q, step_d;
  logic          dir_q, dir_d;
  logic [1:0]    mode_q, mode_d;
  logic          fd_q, fd_d;
  logic          halt, wrap;

`ifdef PAUSE_AT_WRAP_EN
  localparam int            PC     = PAUSE_TICKS * DIV;
  localparam int            PW     = (PC > 1) ? $clog2(PC) : 1;
  localparam logic [PW-1:0] PAUSE_LD = PW'(PC - 1);
  logic [PW-1:0] pcnt_q, pcnt_d;
`endif

  assign halt = stop | ~start;
  assign wrap = (step_q == STEP_TC);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    step_d  = step_q;
    dir_d   = dir_q;
    mode_d  = 2'b00;
    fd_d    = 1'b0;
`ifdef PAUSE_AT_WRAP_EN
    pcnt_d  = pcnt_q;
`endif
    if (reload) begin
      state_d = S_LOAD;
      div_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          mode_d  = 2'b11;
          step_d  = 4'd0;
          div_d   = '0;
          state_d = S_IDLE;
        end
        S_IDLE: begin
          if (start && !stop) begin
            state_d = S_RUN;
            div_d   = '0;
            dir_d   = dir;
          end
        end
        S_RUN: begin
          if (div_q == DIV_TC) begin
            div_d  = '0;
            mode_d = dir_q ? 2'b10 : 2'b01;
            step_d = wrap ? 4'd0 : step_q + 4'd1;
            fd_d   = wrap;
            // bounce freezes dir sampling; direction only flips at the wrap
            if (!bounce)   dir_d = dir;
            else if (wrap) dir_d = ~dir_q;
`ifdef PAUSE_AT_WRAP_EN
            if (wrap) begin
              state_d = S_PAUSE;
              pcnt_d  = PAUSE_LD;
            end
`endif
          end else begin
            div_d = div_q + 1'b1;
          end
          if (halt) begin
            state_d = S_IDLE;
            div_d   = '0;
          end
        end
`ifdef PAUSE_AT_WRAP_EN
        S_PAUSE: begin
          if (halt) begin
            state_d = S_IDLE;
          end else if (pcnt_q == '0) begin
            state_d = S_RUN;
            div_d   = '0;
          end else begin
            pcnt_d = pcnt_q - 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_LOAD;
      div_q   <= '0;
      step_q  <= 4'd0;
      dir_q   <= dir;
      mode_q  <= 2'b00;
      fd_q    <= 1'b0;
`ifdef PAUSE_AT_WRAP_EN
      pcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      fd_q    <= fd_d;
`ifdef PAUSE_AT_WRAP_EN
      pcnt_q  <= pcnt_d;
`endif
    end
  end

  assign ch0        = mode_q[0];
  assign ch1        = mode_q[1];
  assign frame_done = fd_q;
  assign step       = step_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_PAUSE);

endmodule

// File: tb/tb_painel_scroll_controller.sv
// Bench for painel_scroll_controller: directed vector table, bounce sequence, random run against a model.
module tb_painel_scroll_controller;
  localparam int DIV = 4;
  localparam int FL  = 16;
  localparam int PT  = 2;

  logic CLK = 1'b0;
  logic RST, start, stop, reload, dir, bounce;
  logic ch0, ch1, busy, frame_done;
  logic [3:0] step;

  painel_scroll_controller #(.DIV(DIV), .FRAME_LEN(FL), .PAUSE_TICKS(PT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .reload(reload),
    .dir(dir), .bounce(bounce), .ch0(ch0), .ch1(ch1), .busy(busy),
    .step(step), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic st, sp, rl, d, b;
    int   n;
    int   cmd, stp, fd, bsy;
  } vec_t;

  vec_t tbl[$];
  int n_checks = 0;
  int n_fail   = 0;
  int gap, exp_gap;
  bit pause_en;

  // reference model state
  bit m_ld, m_run, m_pause, m_dir;
  int m_ph, m_pos, m_pleft, e_cmd, e_fd;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic st, sp, rl, d, b, input int n,
                              input int cmd, stp, fd, bsy);
    vec_t v;
    v.st = st; v.sp = sp; v.rl = rl; v.d = d; v.b = b; v.n = n;
    v.cmd = cmd; v.stp = stp; v.fd = fd; v.bsy = bsy;
    return v;
  endfunction

  task automatic model_step(input bit st, sp, rl, d, b);
    e_cmd = 0;
    e_fd  = 0;
    if (rl) begin
      m_ld = 1; m_run = 0; m_pause = 0;
    end else if (m_ld) begin
      e_cmd = 3; m_pos = 0; m_ld = 0;
    end else if (m_run) begin
      m_ph++;
      if (m_ph == DIV) begin
        m_ph  = 0;
        e_cmd = m_dir ? 2 : 1;
        m_pos = (m_pos + 1) % FL;
        if (m_pos == 0) begin
          e_fd = 1;
          if (b) m_dir = !m_dir;
          if (pause_en) begin
            m_run = 0; m_pause = 1; m_pleft = PT * DIV;
          end
        end
        if (!b) m_dir = d;
      end
      if (sp || !st) begin
        m_run = 0; m_pause = 0;
      end
    end else if (m_pause) begin
      if (sp || !st) m_pause = 0;
      else begin
        m_pleft--;
        if (m_pleft == 0) begin
          m_pause = 0; m_run = 1; m_ph = 0;
        end
      end
    end else if (st && !sp) begin
      m_run = 1; m_ph = 0; m_dir = d;
    end
  endtask

  initial begin
`ifdef PAUSE_AT_WRAP_EN
    pause_en = 1'b1;
`else
    pause_en = 1'b0;
`endif
    RST = 1; start = 0; stop = 0; reload = 0; dir = 0; bounce = 0;
    tick();
    chk("reset_cmd", {ch1, ch0}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_step", step, 0);
    chk("reset_fd", frame_done, 0);
    tick();
    RST = 0;

    //          st sp rl d  b  n   cmd step fd busy
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3,  0, 0,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 1,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  0, 1,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3,  1, 2,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 5,  0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1,  0, 5,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8,  0, 5,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1,  0, 5,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4,  1, 6,  0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 4,  1, 7,  0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 4,  2, 8,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4,  2, 9,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4,  1, 10, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3,  0, 10, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1,  0, 10, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1,  3, 0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0,  0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; stop = tbl[i].sp; reload = tbl[i].rl;
      dir = tbl[i].d; bounce = tbl[i].b;
      for (int k = 0; k < tbl[i].n; k++) tick();
      chk($sformatf("vec%0d_cmd", i), {ch1, ch0}, tbl[i].cmd);
      chk($sformatf("vec%0d_step", i), step, tbl[i].stp);
      chk($sformatf("vec%0d_fd", i), frame_done, tbl[i].fd);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
    end

    // bounce: 16 left, 16 right, then left again
    start = 1; stop = 0; reload = 0; dir = 0; bounce = 1;
    for (int i = 0; i < 33; i++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while ({ch1, ch0} == 0 && gap < 20);
      if ({ch1, ch0} == 0) begin
        chk("bounce_timeout", 0, 1);
        break;
      end
      if (i == 0)                               exp_gap = DIV + 1;
      else if (pause_en && (i == 16 || i == 32)) exp_gap = PT * DIV + DIV;
      else                                      exp_gap = DIV;
      chk($sformatf("bounce%0d_gap", i), gap, exp_gap);
      chk($sformatf("bounce%0d_cmd", i), {ch1, ch0}, (i >= 16 && i < 32) ? 2 : 1);
      chk($sformatf("bounce%0d_step", i), step, (i + 1) % FL);
      chk($sformatf("bounce%0d_fd", i), frame_done, (i == 15 || i == 31) ? 1 : 0);
    end

    // randomized run against the model
    start = 0; bounce = 0; dir = 0;
    RST = 1;
    tick();
    m_ld = 1; m_run = 0; m_pause = 0; m_pos = 0; m_dir = dir; m_ph = 0; m_pleft = 0;
    e_cmd = 0; e_fd = 0;
    RST = 0;
    for (int c = 0; c < 3000; c++) begin
      start  = ($urandom_range(0, 59) != 0);
      stop   = ($urandom_range(0, 79) == 0);
      reload = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      if ($urandom_range(0, 99) == 0) bounce = ~bounce;
      model_step(start, stop, reload, dir, bounce);
      tick();
      chk("rand_cmd", {ch1, ch0}, e_cmd);
      chk("rand_step", step, m_pos);
      chk("rand_fd", frame_done, e_fd);
      chk("rand_busy", busy, (m_run || m_pause) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/painel_scroll_controller.md
Name: painel_scroll_controller

Overview:
- Command-side sequencer that drives the shared ch0/ch1 mode lines of the 16-bit circular row registers on the electronic panel.
- Issues the preset load after reset, then produces timed single-cycle shift commands so the message rotates at a readable rate.
- Tracks position within the 16-column frame. Supports continuous rotation and bounce (ping-pong) mode.
- One instance drives all row registers in parallel.

Parameters:
- DIV, 50_000_000, CLK cycles per scroll step (≥2).
- FRAME_LEN, 16, columns per frame; the step counter wraps at this value.
- PAUSE_TICKS, 8, steps held at frame wrap (only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- start  in  1  level; begin or continue scrolling.
- stop  in  1  level; halt scrolling, overrides start.
- reload  in  1  pulse; re-issue the preset load.
- dir  in  1  0 = rotate toward higher index (left), 1 = toward lower index (right).
- bounce  in  1  1 = reverse direction at every frame wrap.
- ch0  out  1  mode line bit 0 to the row registers.
- ch1  out  1  mode line bit 1 to the row registers.
- busy  out  1  high while in RUN or PAUSE.
- step  out  4  current column offset, 0..FRAME_LEN-1.
- frame_done  out  1  one-cycle pulse on step wrap.

Behaviour:
- Mode encoding {ch1,ch0}:
  - 00 = hold.
  - 01 = shift left (each register takes its lower neighbour).
  - 10 = shift right.
  - 11 = load preset pattern.
- Every command other than hold lasts exactly one CLK cycle.
- Reset (RST=1 at an edge):
  - state ← LOAD; ch0/ch1 = 00; busy = 0; step = 0; frame_done = 0.
  - Divider counter = 0; effective direction register = dir.
- States: LOAD, IDLE, RUN, PAUSE.
- LOAD:
  - Outputs 11 for one cycle, then goes to IDLE with step = 0.
  - Entered from reset, or from any state when reload=1, which has priority over start/stop.
- IDLE:
  - Outputs 00.
  - If start=1 and stop=0, go to RUN with the divider cleared. Sample dir into the effective direction register.
- RUN:
  - The divider counts 0..DIV-1. On the cycle it reaches DIV-1, output one shift command (01 if effective dir=0, else 10), then clear the divider. All other cycles output 00.
  - The first shift occurs DIV cycles after entering RUN.
  - Each shift increments step modulo FRAME_LEN.
  - The shift that takes step from FRAME_LEN-1 to 0 also pulses frame_done in the same cycle.
  - When bounce=0, dir is re-sampled at every shift, so direction changes take effect on the next step.
  - When bounce=1, the effective direction toggles at each wrap, and dir is ignored until bounce returns to 0.
  - stop=1 (or start=0) → IDLE the next cycle, outputting 00. step is retained and the divider is cleared.
- Simultaneous events:
  - reload beats stop, and stop beats start.
  - A stop asserted on a shift cycle still allows that shift to be output; the transition to IDLE follows.
- A shift command is never output in the same cycle as a load.
- busy = 1 in RUN and PAUSE only.
- step is combinationally derived from a registered counter. ch0, ch1 and frame_done are registered, with no glitches.

Optional Feature:
- Macro: PAUSE_AT_WRAP_EN.
- Defined:
  - After each frame_done shift, go to PAUSE.
  - Hold (00) for PAUSE_TICKS × DIV cycles, then return to RUN with the divider cleared.
  - stop during PAUSE → IDLE; reload → LOAD.
  - busy stays 1 during PAUSE.
- Undefined:
  - No PAUSE state; RUN continues immediately after a wrap.
  - PAUSE_TICKS is unused.

Test Plan (DIV=4, FRAME_LEN=16, PAUSE_TICKS=2):
- Reset release → {ch1,ch0}=11 for exactly 1 cycle, then 00; busy=0, step=0.
- start=1, dir=0 → 01 pulses every 4th cycle, the first 4 cycles after RUN entry; step counts 1,2,…; after the 16th pulse, step=0 and frame_done=1 for 1 cycle.
- start=1, bounce=1 → 16 pulses of 01, then 16 pulses of 10, then 01 again; frame_done at each reversal.
- Running at step=5: stop=1 → IDLE, no further shifts, step stays 5; start again → shifts resume from step 5 → 6 after 4 cycles.
- Running: reload=1 together with stop=1 → 11 for one cycle, then IDLE with step=0; no 01/10 in that cycle.
- PAUSE_AT_WRAP_EN defined: after wrap, 00 for 8 cycles with busy=1; the next 01 arrives 12 cycles after the frame_done cycle.
